mem_arbiter: RTL

- Shares one single-port distributed RAM (`a[15:0]`, `we`, `d[31:0]`, `spo[31:0]`; combinational read, write on the `clk` edge) between two requesters: instruction fetch (read-only) and data (read/write).
- Arbitrates same-cycle conflicts round-robin and registers read data, so responses arrive one cycle after grant.
- Optional power-on sweep zero-fills the RAM before any request is served.
- Sits between the CPU fetch/memory stages and the RAM instance.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_arbiter_rr_arb2.sv | 40 ++++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the two-port memory arbiter.
package mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic {
        CLEAR,
        SERVE
    } state_e;

    typedef enum logic {
        REQ_IF,
        REQ_D
    } req_id_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers the last winner and
// hands a same-cycle conflict to the other requester.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_if,
    input  logic i_req_d,
    output logic o_gnt_if,
    output logic o_gnt_d
);
    import mem_pkg::*;

    req_id_e r_last;

    always_comb begin
        o_gnt_if = 1'b0;
        o_gnt_d  = 1'b0;
        if (i_en) begin
            if (i_req_if && i_req_d) begin
                o_gnt_if = (r_last == REQ_D);
                o_gnt_d  = (r_last == REQ_IF);
            end else begin
                o_gnt_if = i_req_if;
                o_gnt_d  = i_req_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= REQ_D;
        end else if (o_gnt_if) begin
            r_last <= REQ_IF;
        end else if (o_gnt_d) begin
            r_last <= REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between fetch and data requesters,
// with an optional zero-fill sweep after reset.
module mem_arbiter #(
    parameter int ADDR_W         = mem_pkg::ADDR_W,
    parameter int DATA_W         = mem_pkg::DATA_W,
    parameter int DEPTH          = 65536,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_spo,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
    localparam mem_pkg::state_e RST_STATE =
        CLEAR_ON_RESET ? mem_pkg::CLEAR : mem_pkg::SERVE;

    mem_pkg::state_e   r_state;
    mem_pkg::state_e   w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;
    logic [ADDR_W-1:0] r_mem_a;
    logic              r_if_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_serve;
    logic              w_gnt_if;
    logic              w_gnt_d;
    logic              w_d_rd;

    assign w_serve = (r_state == mem_pkg::SERVE);
    assign w_d_rd  = w_gnt_d & ~d_we;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_serve),
        .i_req_if (if_req),
        .i_req_d  (d_req),
        .o_gnt_if (w_gnt_if),
        .o_gnt_d  (w_gnt_d)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        unique case (r_state)
            mem_pkg::CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt = mem_pkg::SERVE;
                end
            end
            mem_pkg::SERVE: begin
                w_state_nxt = mem_pkg::SERVE;
            end
        endcase
    end

    // Idle cycles keep the last address so the RAM port stays quiet.
    always_comb begin
        mem_a  = r_mem_a;
        mem_we = 1'b0;
        mem_d  = '0;
        if (!w_serve) begin
            mem_a  = r_clr_cnt;
            mem_we = 1'b1;
        end else if (w_gnt_if) begin
            mem_a  = if_addr;
        end else if (w_gnt_d) begin
            mem_a  = d_addr;
            mem_we = d_we;
            mem_d  = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= RST_STATE;
            r_clr_cnt <= '0;
            r_mem_a   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_mem_a   <= mem_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= w_gnt_if;
            r_d_rvalid  <= w_d_rd;
            if (w_gnt_if) begin
                r_if_rdata <= mem_spo;
            end
            if (w_d_rd) begin
                r_d_rdata <= mem_spo;
            end
        end
    end

    assign if_gnt    = w_gnt_if;
    assign d_gnt     = w_gnt_d;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign busy      = ~w_serve;

endmodule
